// File: rtl/filter_pkg.sv
// Constants and types shared by the lowpass filter and its coefficient bank.
package filter_pkg;

   localparam int NTAPS = 65;
   localparam int DW    = 18;
   localparam int AW    = 7;

   typedef logic [DW-1:0] coef_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      FULL = 2'd2
   } state_t;

endpackage

// File: rtl/coef_ram_1w1r.sv
// One coefficient bank: single write port, registered read port, async clear.
module coef_ram_1w1r
   import filter_pkg::*;
(
   input  logic          clock,
   input  logic          reset,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   coef_t r_mem [NTAPS];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NTAPS; i++) begin
            r_mem[i] <= '0;
         end
      end else if (we && (waddr < AW'(NTAPS))) begin
         r_mem[waddr] <= wdata;
      end
   end

   // Addresses past the last tap read as zero rather than aliasing.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rdata <= '0;
      end else if (raddr < AW'(NTAPS)) begin
         rdata <= r_mem[raddr];
      end else begin
         rdata <= '0;
      end
   end

endmodule

// File: rtl/coef_bank.sv
// Double-buffered coefficient memory: the filter reads the active bank while
// the host loads the shadow bank; commit swaps them atomically.
module coef_bank
   import filter_pkg::*;
(
   input  logic          clock,
   input  logic          reset,
   input  logic [AW-1:0] coefaddress,
   output logic [DW-1:0] coefdata,
   input  logic          ld_start,
   input  logic          ld_valid,
   input  logic [DW-1:0] ld_data,
   output logic          ld_ready,
   output logic          ld_done,
   input  logic          commit,
   output logic          active_bank,
   output logic          err
);

   state_t        r_state;
   logic [AW-1:0] r_wcnt;
   logic          r_ldReady;
   logic          r_ldDone;
   logic          r_activeBank;
   logic          r_err;
   logic          r_readBank;

   logic          w_we;
   logic          w_we0;
   logic          w_we1;
   logic          w_lastWrite;
   coef_t         w_rdata0;
   coef_t         w_rdata1;

   assign w_we        = (r_state == LOAD) && ld_valid && r_ldReady && !ld_start;
   assign w_lastWrite = w_we && (r_wcnt == AW'(NTAPS - 1));
   assign w_we0       = w_we && r_activeBank;
   assign w_we1       = w_we && !r_activeBank;

   coef_ram_1w1r u_bank0 (
      .clock (clock),
      .reset (reset),
      .we    (w_we0),
      .waddr (r_wcnt),
      .wdata (ld_data),
      .raddr (coefaddress),
      .rdata (w_rdata0)
   );

   coef_ram_1w1r u_bank1 (
      .clock (clock),
      .reset (reset),
      .we    (w_we1),
      .waddr (r_wcnt),
      .wdata (ld_data),
      .raddr (coefaddress),
      .rdata (w_rdata1)
   );

   // The bank select travels with the read data, so a read sampled on the
   // swap edge still comes from the old bank.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_readBank <= 1'b0;
      end else begin
         r_readBank <= r_activeBank;
      end
   end

   assign coefdata = r_readBank ? w_rdata1 : w_rdata0;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state      <= IDLE;
         r_wcnt       <= '0;
         r_ldReady    <= 1'b0;
         r_ldDone     <= 1'b0;
         r_activeBank <= 1'b0;
         r_err        <= 1'b0;
      end else begin
         r_ldDone <= 1'b0;
         case (r_state)
            IDLE: begin
               if (ld_start) begin
                  r_state   <= LOAD;
                  r_wcnt    <= '0;
                  r_err     <= 1'b0;
                  r_ldReady <= 1'b1;
               end else if (commit) begin
                  r_err <= 1'b1;
               end
            end
            LOAD: begin
               if (ld_start) begin
                  r_wcnt    <= '0;
                  r_err     <= 1'b0;
                  r_ldReady <= 1'b1;
               end else begin
                  if (commit) begin
                     r_err <= 1'b1;
                  end
                  if (w_lastWrite) begin
                     r_ldReady <= 1'b0;
                     r_ldDone  <= 1'b1;
                     r_state   <= FULL;
                  end else if (w_we) begin
                     r_wcnt <= r_wcnt + 1'b1;
                  end
               end
            end
            FULL: begin
               // A reload request outranks a simultaneous commit.
               if (ld_start) begin
                  r_state   <= LOAD;
                  r_wcnt    <= '0;
                  r_err     <= 1'b0;
                  r_ldReady <= 1'b1;
               end else if (commit) begin
                  r_activeBank <= ~r_activeBank;
                  r_state      <= IDLE;
               end
            end
            default: begin
               r_state   <= IDLE;
               r_ldReady <= 1'b0;
            end
         endcase
      end
   end

   assign ld_ready    = r_ldReady;
   assign ld_done     = r_ldDone;
   assign active_bank = r_activeBank;
   assign err         = r_err;

endmodule

// File: tb/tb_coef_bank.sv
// Randomized bench for coef_bank with a cycle-level behavioural model.
module tb_coef_bank;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [6:0]  coefaddress = '0;
   logic [17:0] coefdata;
   logic        ld_start = 1'b0;
   logic        ld_valid = 1'b0;
   logic [17:0] ld_data = '0;
   logic        ld_ready;
   logic        ld_done;
   logic        commit = 1'b0;
   logic        active_bank;
   logic        err;

   int total = 0;
   int bad   = 0;

   logic [17:0] mBank [2][65];
   bit          mActive;
   bit          mErr;
   bit          mLoading;
   bit          mFull;
   bit          mReady;
   bit          mDone;
   int          mCnt;
   logic [17:0] mCoef;

   logic [17:0] lastSet [65];
   logic [17:0] oldSet  [65];

   coef_bank dut (
      .clock       (clock),
      .reset       (reset),
      .coefaddress (coefaddress),
      .coefdata    (coefdata),
      .ld_start    (ld_start),
      .ld_valid    (ld_valid),
      .ld_data     (ld_data),
      .ld_ready    (ld_ready),
      .ld_done     (ld_done),
      .commit      (commit),
      .active_bank (active_bank),
      .err         (err)
   );

   always #5 clock = ~clock;

   task checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Model: reads see the bank that was active when the address was sampled;
   // loads fill the inactive bank in index order until 65 words are in.
   always @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int b = 0; b < 2; b++)
            for (int i = 0; i < 65; i++) mBank[b][i] = '0;
         mActive = 0; mErr = 0; mLoading = 0; mFull = 0;
         mReady = 0; mDone = 0; mCnt = 0; mCoef = '0;
      end else begin
         logic [17:0] nextCoef;
         bit accept;
         nextCoef = (coefaddress < 65) ? mBank[mActive][coefaddress] : 18'h0;
         accept = mLoading && ld_valid && !ld_start;
         mDone = 0;
         if (ld_start) begin
            mLoading = 1; mFull = 0; mCnt = 0; mErr = 0;
         end else begin
            if (commit) begin
               if (mFull) begin
                  mActive = !mActive;
                  mFull = 0;
               end else begin
                  mErr = 1;
               end
            end
            if (accept) begin
               mBank[!mActive][mCnt] = ld_data;
               mCnt++;
               if (mCnt == 65) begin
                  mLoading = 0; mFull = 1; mDone = 1;
               end
            end
         end
         mCoef = nextCoef;
         mReady = mLoading;
      end
   end

   always @(negedge clock) begin
      checkVal("coefdata", 32'(coefdata), 32'(mCoef));
      checkVal("ld_ready", 32'(ld_ready), 32'(mReady));
      checkVal("ld_done", 32'(ld_done), 32'(mDone));
      checkVal("active_bank", 32'(active_bank), 32'(mActive));
      checkVal("err", 32'(err), 32'(mErr));
   end

   task tick();
      @(posedge clock);
      #1;
   endtask

   task applyStimulus(input bit seq, input bit toggle);
      int k;
      ld_start = 1'b1;
      tick();
      ld_start = 1'b0;
      for (int i = 0; i < 65; i++) lastSet[i] = seq ? 18'(i + 1) : 18'($urandom);
      k = 0;
      for (int c = 0; c < 200 && k < 65; c++) begin
         ld_valid    = toggle ? (c % 2 == 0) : 1'b1;
         ld_data     = ld_valid ? lastSet[k] : 18'($urandom);
         coefaddress = 7'($urandom_range(0, 127));
         tick();
         if (ld_valid) k++;
      end
      ld_valid = 1'b0;
      tick();
      tick();
   endtask

   task checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checkVal(name, act, exp);
   endtask

   initial begin
      #1 reset = 1'b1;
      repeat (3) tick();
      reset = 1'b0;

      $display("[TB] reset sweep");
      for (int a = 0; a < 65; a++) begin
         coefaddress = 7'(a);
         tick();
      end
      checkOutput("reset_active", 32'(active_bank), 32'd0);
      checkOutput("reset_err", 32'(err), 32'd0);

      $display("[TB] sequential load and commit");
      applyStimulus(1'b1, 1'b0);
      coefaddress = 7'd5;
      tick();
      checkOutput("preCommitZero", 32'(coefdata), 32'd0);
      commit = 1'b1;
      tick();
      commit = 1'b0;
      tick();
      checkOutput("addr5_after_commit", 32'(coefdata), 32'h6);
      checkOutput("active_after_commit", 32'(active_bank), 32'd1);

      $display("[TB] toggled-valid load");
      applyStimulus(1'b0, 1'b1);
      commit = 1'b1;
      tick();
      commit = 1'b0;
      coefaddress = 7'd64;
      tick();
      checkOutput("addr64_word65", 32'(coefdata), 32'(lastSet[64]));
      checkOutput("active_back0", 32'(active_bank), 32'd0);

      $display("[TB] swap during sweep");
      for (int i = 0; i < 65; i++) oldSet[i] = lastSet[i];
      applyStimulus(1'b0, 1'b0);
      for (int a = 0; a < 65; a++) begin
         coefaddress = 7'(a);
         commit = (a == 30);
         tick();
         if (a == 30) checkOutput("swapEdgeOld", 32'(coefdata), 32'(oldSet[30]));
         if (a == 31) checkOutput("afterSwapNew", 32'(coefdata), 32'(lastSet[31]));
      end
      commit = 1'b0;

      $display("[TB] protocol errors");
      commit = 1'b1;
      tick();
      commit = 1'b0;
      checkOutput("idleCommitErr", 32'(err), 32'd1);
      checkOutput("idleCommitNoSwap", 32'(active_bank), 32'd1);
      ld_start = 1'b1;
      tick();
      ld_start = 1'b0;
      checkOutput("startClearsErr", 32'(err), 32'd0);
      applyStimulus(1'b0, 1'b0);
      ld_start = 1'b1;
      commit = 1'b1;
      tick();
      ld_start = 1'b0;
      commit = 1'b0;
      checkOutput("startBeatsCommit", 32'(active_bank), 32'd1);
      checkOutput("reloadReady", 32'(ld_ready), 32'd1);
      tick();

      $display("[TB] random traffic");
      for (int c = 0; c < 1500; c++) begin
         ld_start    = ($urandom_range(0, 39) == 0);
         commit      = !ld_start && ($urandom_range(0, 29) == 0);
         ld_valid    = !ld_start && ($urandom_range(0, 1) == 1);
         ld_data     = 18'($urandom);
         coefaddress = 7'($urandom_range(0, 127));
         tick();
      end
      ld_start = 1'b0;
      commit = 1'b0;
      ld_valid = 1'b0;
      tick();

      $display("[TB] reset mid-load");
      ld_start = 1'b1;
      tick();
      ld_start = 1'b0;
      ld_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         ld_data = 18'($urandom);
         tick();
      end
      ld_valid = 1'b0;
      reset = 1'b1;
      #1;
      checkOutput("rst_coefdata", 32'(coefdata), 32'd0);
      checkOutput("rst_ready", 32'(ld_ready), 32'd0);
      checkOutput("rst_done", 32'(ld_done), 32'd0);
      checkOutput("rst_active", 32'(active_bank), 32'd0);
      checkOutput("rst_err", 32'(err), 32'd0);
      tick();
      reset = 1'b0;
      for (int a = 0; a < 65; a++) begin
         coefaddress = 7'(a);
         tick();
      end
      coefaddress = 7'd100;
      tick();
      checkOutput("addr100_zero", 32'(coefdata), 32'd0);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
